// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM states, counter sizing.
package alu_serial_pkg;

  localparam logic [2:0] OP_H0  = 3'b000;
  localparam logic [2:0] OP_H1  = 3'b001;
  localparam logic [2:0] OP_H2  = 3'b010;
  localparam logic [2:0] OP_H3  = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer around an external 1-bit ALU slice; LSB-first, WIDTH cycles per op.
// Optional ALU_SERIAL_ERR_EN: adds err output and fast-rejects op codes above OP_MAX.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       sel,
  output logic             a_bit,
  output logic             b_bit,
  output logic             cin_bit,
  input  logic             slice_out,
  input  logic             slice_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
`ifdef ALU_SERIAL_ERR_EN
  output logic             err,
`endif
  output logic             zero
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
`ifdef ALU_SERIAL_ERR_EN
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
`ifdef ALU_SERIAL_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
`ifdef ALU_SERIAL_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
`ifdef ALU_SERIAL_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (start_valid) begin
        op_d    = op;
        a_sh_d  = a;
        b_sh_d  = b;
        res_d   = '0;
        cnt_d   = '0;
        carry_d = (op == OP_SUB);
        state_d = RUN;
`ifdef ALU_SERIAL_ERR_EN
        if (op > OP_MAX) begin
          carry_d = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      RUN: begin
        res_d   = {slice_out, res_q[WIDTH-1:1]};
        carry_d = slice_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: if (res_ready) begin
        state_d = IDLE;
`ifdef ALU_SERIAL_ERR_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice drives are forced to zero outside RUN so the mux sees a quiet input.
  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign sel         = (state_q == RUN) ? op_q : 3'b000;
  assign a_bit       = (state_q == RUN) & a_sh_q[0];
  assign b_bit       = (state_q == RUN) & (b_sh_q[0] ^ (op_q == OP_SUB));
  assign cin_bit     = (state_q == RUN) & carry_q;
  assign result      = res_q;
  assign carry       = carry_q & ((op_q == OP_ADD) | (op_q == OP_SUB));
  assign zero        = (res_q == '0);
`ifdef ALU_SERIAL_ERR_EN
  assign err         = err_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed table-driven bench for alu_serial_ctrl with a behavioural 1-bit slice model.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   sel;
  logic         a_bit, b_bit, cin_bit;
  logic         slice_out, slice_cout;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, zero;
`ifdef ALU_SERIAL_ERR_EN
  logic         err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    slice_cout = (a_bit & b_bit) | (a_bit & cin_bit) | (b_bit & cin_bit);
    case (sel)
      3'd0:    slice_out = a_bit & b_bit;
      3'd1:    slice_out = a_bit | b_bit;
      3'd2:    slice_out = a_bit ^ b_bit;
      3'd3:    slice_out = ~(a_bit | b_bit);
      3'd4,
      3'd5:    slice_out = a_bit ^ b_bit ^ cin_bit;
      default: slice_out = 1'b0;
    endcase
  end

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b),
    .sel(sel), .a_bit(a_bit), .b_bit(b_bit), .cin_bit(cin_bit),
    .slice_out(slice_out), .slice_cout(slice_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry(carry),
`ifdef ALU_SERIAL_ERR_EN
    .err(err),
`endif
    .zero(zero)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res;
    logic         cy, z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one op, returns the number of posedges (accept edge included) until res_valid.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                       output int lat);
    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    start_valid = 1'b1; op = o; a = va; b = vb;
    lat = 0;
    do begin
      @(negedge clk);
      start_valid = 1'b0;
      lat++;
    end while (!res_valid && lat < 40);
    if (lat >= 40) check("res_valid_timeout", 0, 1);
  endtask

  task automatic release_done();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_fall", res_valid, 0);
    check("start_ready_rise", start_ready, 1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;

    vecs[0] = '{3'b100, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{3'b101, 8'h05, 8'h06, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{3'b101, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{3'b010, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[6] = '{3'b001, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0};
    vecs[7] = '{3'b011, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0};

    #2;
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_sel", sel, 0);
    @(negedge clk); rst_n = 1'b1;
    check("rst_start_ready", start_ready, 1);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("lat_%0d", i), lat, W + 1);
      check($sformatf("res_%0d", i), result, vecs[i].res);
      check($sformatf("carry_%0d", i), carry, vecs[i].cy);
      check($sformatf("zero_%0d", i), zero, vecs[i].z);
      check($sformatf("drv_idle_%0d", i), {sel, a_bit, b_bit, cin_bit}, 0);
      release_done();
    end

    // SUB drive check on the first RUN cycle: inverted b bit, carry-in 1.
    @(negedge clk);
    start_valid = 1'b1; op = 3'b101; a = 8'h00; b = 8'h00;
    @(negedge clk);
    start_valid = 1'b0;
    check("sub_sel", sel, 3'b101);
    check("sub_b_bit", b_bit, 1);
    check("sub_cin", cin_bit, 1);
    lat = 1;
    while (!res_valid && lat < 40) begin @(negedge clk); lat++; end
    check("sub_zero_res", result, 8'h00);
    check("sub_zero_cy", carry, 1);
    release_done();

    // Back-pressure: DONE holds and start_valid is ignored.
    issue(3'b010, 8'hA5, 8'hFF, lat);
    held = result;
    start_valid = 1'b1; op = 3'b100; a = 8'h11; b = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_result", result, held);
      check("hold_valid", res_valid, 1);
      check("hold_start_ready", start_ready, 0);
    end
    start_valid = 1'b0;
    check("hold_value", held, 8'h5A);
    release_done();
    @(negedge clk);
    check("hold_no_accept", start_ready, 1);

    // Reset during RUN at cnt==3.
    start_valid = 1'b1; op = 3'b100; a = 8'h3C; b = 8'h05;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_sel", sel, 3'b100);
    rst_n = 1'b0;
    #1;
    check("mrst_res_valid", res_valid, 0);
    check("mrst_result", result, 0);
    check("mrst_carry", carry, 0);
    check("mrst_zero", zero, 1);
    check("mrst_drives", {sel, a_bit, b_bit, cin_bit}, 0);
    check("mrst_start_ready", start_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    issue(3'b000, 8'hF0, 8'h3C, lat);
    check("post_rst_lat", lat, W + 1);
    check("post_rst_and", result, 8'h30);
    release_done();

    // Out-of-range op code.
    issue(3'b110, 8'h12, 8'h34, lat);
`ifdef ALU_SERIAL_ERR_EN
    check("err_lat", lat, 1);
    check("err_flag", err, 1);
    check("err_result", result, 0);
    check("err_zero", zero, 1);
    check("err_carry", carry, 0);
    release_done();
    check("err_clear", err, 0);
`else
    check("op6_lat", lat, W + 1);
    check("op6_result", result, 0);
    check("op6_carry", carry, 0);
    release_done();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
